// File: rtl/aemb_wbarb_pkg.sv
// aemb_wbarb_pkg: shared state encodings, watchdog width and clog2 for the N-master arbiter
package aemb_wbarb_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_ERR = 2'd2} state_e;
  localparam int TMO_CW = 8;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/aemb_rrpick.sv
// aemb_rrpick: combinational round-robin picker, first requester searching upward from last+1
module aemb_rrpick
  import aemb_wbarb_pkg::*;
#(
  parameter  int NM = 2,
  localparam int IW = clog2(NM)
) (
  input  logic [NM-1:0] req_i,
  input  logic [IW-1:0] last_i,
  output logic [NM-1:0] gnt_o,
  output logic [IW-1:0] idx_o
);
  // Scan from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = NM; i >= 1; i--) begin
      if (req_i[(int'(last_i) + i) % NM]) begin
        gnt_o = NM'(1) << ((int'(last_i) + i) % NM);
        idx_o = IW'((int'(last_i) + i) % NM);
      end
    end
  end
endmodule

// File: rtl/aemb_wbarbn.sv
// aemb_wbarbn: N-master round-robin Wishbone arbiter with cyc locking.
// Define AEMB_WBARB_TMO_EN to add a watchdog that error-terminates stalled strobes.
module aemb_wbarbn
  import aemb_wbarb_pkg::*;
#(
  parameter int NM  = 2,
  parameter int AW  = 32,
  parameter int TMO = 16
) (
  input  logic               sys_clk_i,
  input  logic               sys_rst_i,
  input  logic [NM*(AW-2)-1:0] cwb_adr_o,
  input  logic [NM*32-1:0]   cwb_dat_o,
  input  logic [NM*4-1:0]    cwb_sel_o,
  input  logic [NM-1:0]      cwb_stb_o,
  input  logic [NM-1:0]      cwb_cyc_o,
  input  logic [NM-1:0]      cwb_wre_o,
  input  logic [NM-1:0]      cwb_tag_o,
  output logic [31:0]        cwb_dat_i,
  output logic [NM-1:0]      cwb_ack_i,
  output logic [NM-1:0]      cwb_err_i,
  output logic [AW-3:0]      mwb_adr_o,
  output logic [31:0]        mwb_dat_o,
  output logic [3:0]         mwb_sel_o,
  output logic               mwb_stb_o,
  output logic               mwb_cyc_o,
  output logic               mwb_wre_o,
  output logic               mwb_tag_o,
  input  logic [31:0]        mwb_dat_i,
  input  logic               mwb_ack_i,
  output logic [NM-1:0]      gnt_o
);
  localparam int IW = clog2(NM);
  localparam int AB = AW - 2;
  state_e state_q, state_d;
  logic [NM-1:0] gnt_q, gnt_d, pick_gnt;
  logic [IW-1:0] last_q, last_d, pick_idx;
  logic busy, cyc_g, stall;
  aemb_rrpick #(.NM(NM)) u_pick (
    .req_i (cwb_cyc_o),
    .last_i(last_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );
  // last_q doubles as the granted index while a grant is held
  assign busy  = state_q == ST_BUSY;
  assign cyc_g = cwb_cyc_o[last_q];
  assign stall = busy && mwb_stb_o && !mwb_ack_i;
  assign gnt_o = gnt_q;
`ifdef AEMB_WBARB_TMO_EN
  logic [TMO_CW-1:0] cnt_q, cnt_d;
  always_ff @(posedge sys_clk_i or posedge sys_rst_i)
    if (sys_rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
`endif
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NM - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    if (state_q == ST_IDLE) begin
      if (|cwb_cyc_o) begin
        state_d = ST_BUSY;
        gnt_d   = pick_gnt;
        last_d  = pick_idx;
      end
    end else if (!cyc_g) begin
      state_d = ST_IDLE;
      gnt_d   = '0;
    end
`ifdef AEMB_WBARB_TMO_EN
    else if (state_q == ST_ERR) state_d = ST_BUSY;
    else if (stall && cnt_q == TMO_CW'(TMO - 1)) state_d = ST_ERR;
    cnt_d = (stall && state_d == ST_BUSY) ? cnt_q + 1'b1 : '0;
`endif
  end
  always_comb begin
    cwb_dat_i = mwb_dat_i;
    mwb_adr_o = busy ? cwb_adr_o[int'(last_q)*AB +: AB] : '0;
    mwb_dat_o = busy ? cwb_dat_o[int'(last_q)*32 +: 32] : '0;
    mwb_sel_o = busy ? cwb_sel_o[int'(last_q)*4 +: 4] : '0;
    mwb_stb_o = busy ? cwb_stb_o[last_q] : 1'b0;
    mwb_cyc_o = busy ? cyc_g : 1'b0;
    mwb_wre_o = busy ? cwb_wre_o[last_q] : 1'b0;
    mwb_tag_o = busy ? cwb_tag_o[last_q] : 1'b0;
    cwb_ack_i = busy ? gnt_q & {NM{mwb_ack_i}} : '0;
    cwb_err_i = (state_q == ST_ERR) ? gnt_q : '0;
  end
endmodule

// File: tb/tb_aemb_wbarbn.sv
// tb_aemb_wbarbn: directed and randomized checks of the 3-master arbiter against a behavioural model
module tb_aemb_wbarbn;
`ifdef AEMB_WBARB_TMO_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [89:0] c_adr;
  logic [95:0] c_dat;
  logic [11:0] c_sel;
  logic [2:0] c_stb, c_cyc, c_wre, c_tag;
  logic [31:0] c_dat_i;
  logic [2:0] c_ack, c_err, gnt;
  logic [29:0] m_adr;
  logic [31:0] m_dat, m_dat_i;
  logic [3:0] m_sel;
  logic m_stb, m_cyc, m_wre, m_tag, m_ack;
  int checks = 0, passed = 0;

  aemb_wbarbn #(.NM(3), .AW(32), .TMO(16)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .cwb_adr_o(c_adr), .cwb_dat_o(c_dat), .cwb_sel_o(c_sel),
    .cwb_stb_o(c_stb), .cwb_cyc_o(c_cyc), .cwb_wre_o(c_wre), .cwb_tag_o(c_tag),
    .cwb_dat_i(c_dat_i), .cwb_ack_i(c_ack), .cwb_err_i(c_err),
    .mwb_adr_o(m_adr), .mwb_dat_o(m_dat), .mwb_sel_o(m_sel),
    .mwb_stb_o(m_stb), .mwb_cyc_o(m_cyc), .mwb_wre_o(m_wre), .mwb_tag_o(m_tag),
    .mwb_dat_i(m_dat_i), .mwb_ack_i(m_ack), .gnt_o(gnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    c_adr = '0; c_dat = '0; c_sel = '0;
    c_stb = '0; c_cyc = '0; c_wre = '0; c_tag = '0;
    m_dat_i = '0; m_ack = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    c_cyc = 3'b111; c_stb = 3'b111; m_ack = 1'b1; c_adr = {3{30'h2aaa_5555}};
    tick();
    tick();
    checks++; if (gnt !== 3'b000) $display("FAIL reset_gnt: got %b want 000", gnt); else passed++;
    checks++; if (m_stb !== 1'b0 || m_cyc !== 1'b0) $display("FAIL reset_stbcyc: got %b%b want 00", m_stb, m_cyc); else passed++;
    checks++; if (c_ack !== 3'b000) $display("FAIL reset_ack: got %b want 000", c_ack); else passed++;
    checks++; if (c_err !== 3'b000) $display("FAIL reset_err: got %b want 000", c_err); else passed++;
    checks++; if (m_adr !== 30'h0) $display("FAIL reset_adr: got %h want 0", m_adr); else passed++;
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_grant_latency;
    logic [29:0] a;
    logic [31:0] d;
    do_reset();
    repeat (3) tick();
    a = 30'($urandom);
    d = $urandom;
    c_cyc = 3'b010; c_stb = 3'b010; c_adr[30 +: 30] = a;
    #1;
    checks++; if (gnt !== 3'b000) $display("FAIL lat_pre_gnt: got %b want 000", gnt); else passed++;
    tick();
    checks++; if (gnt !== 3'b010) $display("FAIL lat_gnt: got %b want 010", gnt); else passed++;
    checks++; if (m_stb !== 1'b1) $display("FAIL lat_stb: got %b want 1", m_stb); else passed++;
    checks++; if (m_adr !== a) $display("FAIL lat_adr: got %h want %h", m_adr, a); else passed++;
    tick();
    tick();
    m_ack = 1'b1; m_dat_i = d;
    #1;
    checks++; if (c_ack !== 3'b010) $display("FAIL lat_ack: got %b want 010", c_ack); else passed++;
    checks++; if (c_dat_i !== d) $display("FAIL lat_dat: got %h want %h", c_dat_i, d); else passed++;
    m_ack = 1'b0; c_cyc = '0; c_stb = '0;
    tick();
    checks++; if (gnt !== 3'b000) $display("FAIL lat_release: got %b want 000", gnt); else passed++;
  endtask

  task automatic test_round_robin;
    int exp_order[4] = '{0, 1, 2, 0};
    logic [2:0] want;
    do_reset();
    c_cyc = 3'b111; c_stb = 3'b111;
    for (int n = 0; n < 4; n++) begin
      want = 3'(1 << exp_order[n]);
      tick();
      checks++; if (gnt !== want) $display("FAIL rr_gnt%0d: got %b want %b", n, gnt, want); else passed++;
      m_ack = 1'b1;
      c_cyc[exp_order[n]] = 1'b0;
      c_stb[exp_order[n]] = 1'b0;
      #1;
      checks++; if (c_ack !== want) $display("FAIL rr_ack%0d: got %b want %b", n, c_ack, want); else passed++;
      tick();
      m_ack = 1'b0;
      checks++; if (gnt !== 3'b000) $display("FAIL rr_dead%0d: got %b want 000", n, gnt); else passed++;
      c_cyc[exp_order[n]] = 1'b1;
      c_stb[exp_order[n]] = 1'b1;
    end
    clear_inputs();
  endtask

  task automatic test_lock;
    int ack1 = 0, lost = 0, acks0 = 0;
    do_reset();
    c_cyc = 3'b011; c_stb = 3'b011;
    tick();
    checks++; if (gnt !== 3'b001) $display("FAIL lock_first: got %b want 001", gnt); else passed++;
    for (int i = 0; i < 8; i++) begin
      c_stb[0] = ~i[0];
      m_ack = ~i[0];
      #1;
      if (c_ack[1]) ack1++;
      if (gnt !== 3'b001) lost++;
      if (c_ack[0]) acks0++;
      tick();
    end
    checks++; if (lost !== 0) $display("FAIL lock_hold: got %0d lost cycles want 0", lost); else passed++;
    checks++; if (ack1 !== 0) $display("FAIL lock_ack1: got %0d acks want 0", ack1); else passed++;
    checks++; if (acks0 !== 4) $display("FAIL lock_ack0: got %0d acks want 4", acks0); else passed++;
    m_ack = 1'b0; c_cyc[0] = 1'b0; c_stb[0] = 1'b0;
    tick();
    checks++; if (gnt !== 3'b000) $display("FAIL lock_dead: got %b want 000", gnt); else passed++;
    tick();
    checks++; if (gnt !== 3'b010) $display("FAIL lock_next: got %b want 010", gnt); else passed++;
    clear_inputs();
  endtask

  task automatic test_reset_mid;
    do_reset();
    c_cyc = 3'b100; c_stb = 3'b100; c_wre = 3'b100; c_sel[8 +: 4] = 4'hf;
    tick();
    checks++; if (m_stb !== 1'b1 || m_wre !== 1'b1) $display("FAIL mid_busy: got stb=%b wre=%b want 11", m_stb, m_wre); else passed++;
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({m_stb, m_cyc, m_wre, m_sel} !== 7'h0) $display("FAIL mid_async: got %h want 0", {m_stb, m_cyc, m_wre, m_sel}); else passed++;
    checks++; if (gnt !== 3'b000) $display("FAIL mid_gnt: got %b want 000", gnt); else passed++;
    rst = 1'b0;
    c_cyc = 3'b101; c_stb = 3'b101;
    tick();
    checks++; if (gnt !== 3'b001) $display("FAIL mid_first: got %b want 001", gnt); else passed++;
    clear_inputs();
  endtask

  task automatic test_watchdog;
    int at = 0, errs = 0, lost = 0;
    do_reset();
    c_cyc = 3'b010; c_stb = 3'b010;
    tick();
    checks++; if (gnt !== 3'b010) $display("FAIL wd_gnt: got %b want 010", gnt); else passed++;
    if (TMO_EN) begin
      for (int i = 1; i <= 30; i++) begin
        tick();
        if (c_err !== 3'b000) begin
          at = i;
          break;
        end
      end
      checks++; if (at !== 16) $display("FAIL wd_time: got %0d want 16", at); else passed++;
      checks++; if (c_err !== 3'b010) $display("FAIL wd_err: got %b want 010", c_err); else passed++;
      checks++; if (m_stb !== 1'b0 || m_cyc !== 1'b0) $display("FAIL wd_stb: got %b%b want 00", m_stb, m_cyc); else passed++;
      c_cyc = '0; c_stb = '0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (c_err !== 3'b000) errs++;
      end
      checks++; if (errs !== 0) $display("FAIL wd_once: got %0d extra pulses want 0", errs); else passed++;
    end else begin
      for (int i = 0; i < 1000; i++) begin
        tick();
        if (c_err !== 3'b000) errs++;
        if (gnt !== 3'b010 || m_stb !== 1'b1) lost++;
      end
      checks++; if (errs !== 0) $display("FAIL wd_noerr: got %0d err cycles want 0", errs); else passed++;
      checks++; if (lost !== 0) $display("FAIL wd_hold: got %0d lost cycles want 0", lost); else passed++;
    end
    clear_inputs();
  endtask

  task automatic test_random;
    int owner = -1, last = 2, stall = 0, nxt;
    bit err = 0;
    logic [2:0] e_gnt, e_ack, e_err;
    logic e_stb;
    logic [29:0] e_adr;
    logic [31:0] e_dat;
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        if (!c_cyc[k]) c_cyc[k] = ($urandom % 3) == 0;
        else if (($urandom % 4) == 0) c_cyc[k] = 1'b0;
        c_stb[k] = c_cyc[k] && (($urandom % 2) == 1);
        c_wre[k] = 1'($urandom);
        c_tag[k] = 1'($urandom);
        c_adr[k*30 +: 30] = 30'($urandom);
        c_dat[k*32 +: 32] = $urandom;
        c_sel[k*4 +: 4] = 4'($urandom);
      end
      m_ack = 1'($urandom);
      m_dat_i = $urandom;
      #1;
      e_gnt = (owner < 0) ? 3'b000 : 3'(1 << owner);
      e_stb = (owner >= 0 && !err) ? c_stb[owner] : 1'b0;
      e_ack = (owner >= 0 && !err && m_ack) ? 3'(1 << owner) : 3'b000;
      e_err = err ? 3'(1 << owner) : 3'b000;
      e_adr = (owner >= 0 && !err) ? c_adr[owner*30 +: 30] : 30'h0;
      e_dat = (owner >= 0 && !err) ? c_dat[owner*32 +: 32] : 32'h0;
      checks++; if (gnt !== e_gnt) $display("FAIL rnd_gnt@%0d: got %b want %b", cyc, gnt, e_gnt); else passed++;
      checks++; if (m_stb !== e_stb) $display("FAIL rnd_stb@%0d: got %b want %b", cyc, m_stb, e_stb); else passed++;
      checks++; if (c_ack !== e_ack) $display("FAIL rnd_ack@%0d: got %b want %b", cyc, c_ack, e_ack); else passed++;
      checks++; if (c_err !== e_err) $display("FAIL rnd_err@%0d: got %b want %b", cyc, c_err, e_err); else passed++;
      checks++; if (m_adr !== e_adr || m_dat !== e_dat) $display("FAIL rnd_bus@%0d: got %h/%h want %h/%h", cyc, m_adr, m_dat, e_adr, e_dat); else passed++;
      checks++; if (c_dat_i !== m_dat_i) $display("FAIL rnd_rdat@%0d: got %h want %h", cyc, c_dat_i, m_dat_i); else passed++;
      // Advance the model with the inputs the DUT samples at the coming edge.
      if (owner < 0) begin
        if (|c_cyc) begin
          nxt = 0;
          for (int i = 3; i >= 1; i--) if (c_cyc[(last + i) % 3]) nxt = (last + i) % 3;
          owner = nxt;
          last = nxt;
        end
      end else if (!c_cyc[owner]) begin
        owner = -1; err = 0; stall = 0;
      end else if (err) begin
        err = 0; stall = 0;
      end else if (c_stb[owner] && !m_ack) begin
        if (TMO_EN && stall == 15) begin
          err = 1; stall = 0;
        end else stall++;
      end else stall = 0;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_grant_latency();
    test_round_robin();
    test_lock();
    test_reset_mid();
    test_watchdog();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/aemb_wbarbn.md
# aemb_wbarbn

Parametrised N-master Wishbone arbiter for aeMB2 SoC tops, replacing the fixed two-port data/XSL arbiter. Any number of bus masters (CPU data port, XSL port, DMA, debug) share one memory-side port (`mwb_*`) into the unified RAM or peripheral fabric. Arbitration is round-robin with cycle locking on `cyc`. An optional watchdog terminates stalled transfers with an error strobe.

## Interface
- `NM`, 2, number of masters (2..8)
- `AW`, 32, address width; buses carry `[AW-1:2]`
- `TMO`, 16, watchdog limit in cycles without ack (4..255)
- `sys_clk_i` in 1: single clock.
- `sys_rst_i` in 1: asynchronous, active-high reset.
- `cwb_adr_o` in NM*(AW-2): master addresses. Master k uses slice k.
- `cwb_dat_o` in NM*32: master write data.
- `cwb_sel_o` in NM*4: master byte selects.
- `cwb_stb_o`, `cwb_cyc_o`, `cwb_wre_o`, `cwb_tag_o` in NM each: master strobe, cycle, write enable, tag.
- `cwb_dat_i` out 32: read data, broadcast to all masters.
- `cwb_ack_i` out NM: per-master ack, granted master only.
- `cwb_err_i` out NM: per-master watchdog error strobe.
- `mwb_adr_o` out AW-2: slave-side address, forwarded from the granted master.
- `mwb_dat_o` out 32, `mwb_sel_o` out 4, `mwb_stb_o`/`mwb_cyc_o`/`mwb_wre_o`/`mwb_tag_o` out 1: slave-side data, select and control, forwarded from the granted master.
- `mwb_dat_i` in 32, `mwb_ack_i` in 1: slave response.
- `gnt_o` out NM: one-hot registered grant; all zero when idle.

## Operation
- FSM states: IDLE, BUSY; ERR only when the watchdog is compiled in.
- **IDLE**
  - If any `cwb_cyc_o[k]` is high, pick the first requester searching from `last+1` upward, modulo NM.
  - Register `gnt_o` to that master, set `last` to its index, go to BUSY.
  - All `mwb_*` outputs are 0.
- **BUSY**
  - `mwb_*` are a combinational mux of the granted master's signals.
  - `cwb_ack_i[g] = mwb_ack_i`; every other ack bit is 0.
  - `cwb_dat_i = mwb_dat_i` in every state.
  - Grant holds while `cwb_cyc_o[g]` stays high; multiple strobes may be issued under one `cyc`.
  - When `cwb_cyc_o[g]` drops, go to IDLE and clear `gnt_o`.
- Non-granted masters see no ack and simply wait; they are not starved.
- Round-robin: a continuously requesting master is served within NM grants.
- Simultaneous `cwb_cyc_o[g]` fall and `mwb_ack_i`: the ack is routed, then the FSM goes to IDLE.
- Ack while stb is low: passed through unchanged; the arbiter does not police the slave.
- Reset (any time, including mid-transfer):
  - state IDLE, `gnt_o` = 0, `last` = NM-1 (master 0 wins first), watchdog count 0.
  - all `mwb_*`, `cwb_ack_i` and `cwb_err_i` are 0.

## Timing
- Grant latency: request sampled at edge 0, `gnt_o` and `mwb_stb_o` valid from edge 1 (one cycle).
- Ack path is combinational, zero latency: `mwb_ack_i` to `cwb_ack_i`.
- Re-arbitration: one dead IDLE cycle between consecutive grants, including back-to-back grants to the same master.
- Watchdog counter, 8 bits:
  - increments each BUSY cycle with `mwb_stb_o`=1 and `mwb_ack_i`=0;
  - clears on ack, on a BUSY exit, or when stb is low.

## Configuration
- Macro: `AEMB_WBARB_TMO_EN`.
- **Defined:**
  - when the count reaches TMO-1 with stb high and no ack, enter ERR for exactly one cycle;
  - in ERR: `cwb_err_i[g]`=1, `mwb_stb_o`=0, `mwb_cyc_o`=0, count cleared;
  - next state is BUSY if `cwb_cyc_o[g]` is still high, else IDLE.
- **Undefined:** no counter, no ERR state; `cwb_err_i` is tied to 0 and stalls are unbounded.

## Structure
- Shared package/include `aemb_wbarb_pkg`:
  - state encodings (IDLE=2'd0, BUSY=2'd1, ERR=2'd2);
  - `clog2` function;
  - TMO counter width constant (8).
- One sub-module, `aemb_rrpick`: combinational round-robin picker. Inputs: request vector, last index. Outputs: one-hot grant, index.
- Slice mux and FSM live in `aemb_wbarbn`.

## Test plan
- Reset release, NM=3, master 1 raises `cyc`/`stb` at cycle 5:
  - `gnt_o`=3'b010 and `mwb_stb_o`=1 at cycle 6;
  - slave ack at 8 gives `cwb_ack_i`=3'b010 at 8.
- All three masters hold `cyc` continuously, each dropping it after one acked read:
  - grant order 0,1,2,0 with one IDLE cycle between grants.
- Master 0 issues 4 strobes under one `cyc` while master 1 requests:
  - master 1 is not granted until master 0 drops `cyc`;
  - `cwb_ack_i[1]` stays 0 throughout.
- Assert `sys_rst_i` mid-write (BUSY, stb high):
  - all `mwb_*` go to 0 without waiting for a clock edge;
  - after release, master 0 wins the first grant.
- With `AEMB_WBARB_TMO_EN` and TMO=16, slave never acks:
  - `cwb_err_i[g]` pulses once, 16 cycles after stb rises (count reaches TMO-1 = 15);
  - `mwb_stb_o`=0 during that cycle.
- Without `AEMB_WBARB_TMO_EN`, same stimulus: `cwb_err_i` stays 0 for 1000 cycles and the grant holds.
